// File: rtl/fifo_slice_drain.sv
// Drains words from an upstream FIFO and emits each word as N slices of SLICE bits, MSB slice first.
// Each fully transmitted word increments a wrapping word counter.
module fifo_slice_drain #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned SLICE = 9,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_read_data,
  output logic             fifo_RE,
  output logic [SLICE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, POP, LOAD, SEND} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] hold;
  logic [SLICE-1:0] slice;
  logic             final_slice;

  assign final_slice = (idx == IDX_W'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      hold       <= '0;
      word_count <= '0;
    end else begin
      case (state)
        IDLE: if (!fifo_empty) state <= POP;
        POP:  state <= LOAD;
        LOAD: begin
          hold  <= fifo_read_data;
          idx   <= '0;
          state <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (final_slice) begin
              word_count <= word_count + CNT_W'(1);
              state      <= fifo_empty ? IDLE : POP;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slice mux written as a constant-index loop so each part-select is static.
  always_comb begin
    slice = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) slice = hold[WIDTH-1-i*SLICE -: SLICE];
    end
  end

  assign fifo_RE   = (state == POP);
  assign out_valid = (state == SEND);
  assign out_last  = (state == SEND) && final_slice;
  assign busy      = (state != IDLE);
  assign out_data  = (state == SEND) ? slice : '0;

endmodule

// File: tb/tb_fifo_slice_drain.sv
// Scoreboard bench for fifo_slice_drain: directed words feed a FIFO model and push expected slices;
// a negedge monitor pops and compares on every transfer. A second, narrow-counter instance covers wrap.
module tb_fifo_slice_drain;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        reset2;
  logic        out_ready;
  logic [35:0] fifo_read_data = '0;
  logic [35:0] fifo_q[$];
  logic        fifo_empty;
  logic        fifo_RE;
  logic [8:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        busy;
  logic [15:0] word_count;

  logic        fifo_RE_w;
  logic [8:0]  out_data_w;
  logic        out_valid_w;
  logic        out_last_w;
  logic        busy_w;
  logic [3:0]  word_count_w;

  logic [9:0]  exp_q[$];
  int          re_log[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  assign fifo_empty = (fifo_q.size() == 0);

  fifo_slice_drain #(.WIDTH(36), .SLICE(9), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
    .fifo_RE(fifo_RE), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .word_count(word_count)
  );

  fifo_slice_drain #(.WIDTH(36), .SLICE(9), .CNT_W(4)) dut_wrap (
    .clk(clk), .reset(reset2), .fifo_empty(1'b0), .fifo_read_data(36'h0),
    .fifo_RE(fifo_RE_w), .out_data(out_data_w), .out_valid(out_valid_w), .out_ready(1'b1),
    .out_last(out_last_w), .busy(busy_w), .word_count(word_count_w)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream FIFO model: data appears the cycle after fifo_RE.
  always @(posedge clk) begin
    if (fifo_RE && fifo_q.size() > 0) fifo_read_data <= fifo_q.pop_front();
  end

  // Main monitor: scoreboard pop on each transfer, plus idle-zero and read-enable legality.
  always @(negedge clk) begin
    logic [9:0] e;
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_slice", {out_last, out_data}, 10'h3ff);
        else begin
          e = exp_q.pop_front();
          chk("slice", {out_last, out_data}, e);
        end
      end
      if (!out_valid) chk("idle_data_zero", {out_last, out_data}, 0);
      if (fifo_RE) begin
        chk("re_nonempty", fifo_q.size() > 0, 1);
        re_log.push_back(cyc);
      end
    end
  end

  // Wrap monitor for the 4-bit counter instance.
  logic [3:0] wc_model = '0;
  bit         pend = 1'b0;
  bit         saw_wrap = 1'b0;
  always @(negedge clk) begin
    if (!reset2) begin
      if (pend) begin
        chk("wrap_count", word_count_w, wc_model);
        if (wc_model == 4'd0) saw_wrap = 1'b1;
        pend = 1'b0;
      end
      if (out_valid_w && out_last_w) begin
        wc_model = wc_model + 4'd1;
        pend = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [8:0] s0, input logic [8:0] s1,
                           input logic [8:0] s2, input logic [8:0] s3);
    fifo_q.push_back({s0, s1, s2, s3});
    exp_q.push_back({1'b0, s0});
    exp_q.push_back({1'b0, s1});
    exp_q.push_back({1'b0, s2});
    exp_q.push_back({1'b1, s3});
  endtask

  task automatic wait_valid(input string name, input int exp_edges);
    int n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (out_valid) break;
    end
    chk(name, n, exp_edges);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!busy && exp_q.size() == 0 && fifo_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", done, 1);
  endtask

  initial begin
    reset = 1'b1;
    reset2 = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    chk("reset_state", {fifo_RE, busy, out_valid, out_last, out_data, word_count}, 0);
    reset = 1'b0;
    reset2 = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step();
      chk("empty_idle", {fifo_RE, busy, out_valid, out_data, word_count}, 0);
    end

    // Single word, ready high: hand-sliced 36'h123456789
    out_ready = 1'b1;
    fifo_q.push_back(36'h123456789);
    exp_q.push_back({1'b0, 9'h024});
    exp_q.push_back({1'b0, 9'h0D1});
    exp_q.push_back({1'b0, 9'h0B3});
    exp_q.push_back({1'b1, 9'h189});
    wait_valid("first_latency", 3);
    wait_idle();
    chk("count_after_one", word_count, 1);
    chk("idle_after_one", busy, 0);

    // Three back-to-back words
    re_log.delete();
    push_word(9'h1A5, 9'h05A, 9'h0FF, 9'h100);
    push_word(9'h001, 9'h002, 9'h003, 9'h004);
    push_word(9'h1FF, 9'h000, 9'h155, 9'h0AA);
    wait_idle();
    chk("re_pulses", re_log.size(), 3);
    if (re_log.size() == 3) begin
      chk("re_gap_1", re_log[1] - re_log[0], 6);
      chk("re_gap_2", re_log[2] - re_log[1], 6);
    end
    chk("count_after_four", word_count, 4);

    // Backpressure at idx=2 with another word waiting upstream
    out_ready = 1'b0;
    push_word(9'h111, 9'h022, 9'h1C3, 9'h0E7);
    push_word(9'h0C0, 9'h13F, 9'h066, 9'h199);
    wait_valid("stall_latency", 3);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold", {out_valid, fifo_RE, out_last, out_data}, {1'b1, 1'b0, 1'b0, 9'h1C3});
    end
    out_ready = 1'b1;
    wait_idle();
    chk("count_after_six", word_count, 6);

    // Reset while sending idx=1
    out_ready = 1'b0;
    push_word(9'h0AB, 9'h0CD, 9'h0EF, 9'h012);
    wait_valid("pre_reset_latency", 3);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("at_idx1", {out_valid, out_data}, {1'b1, 9'h0CD});
    reset = 1'b1;
    step();
    chk("mid_reset_outputs", {fifo_RE, busy, out_valid, out_last, out_data, word_count}, 0);
    reset = 1'b0;
    exp_q.delete();
    re_log.delete();
    for (int i = 0; i < 3; i++) step();
    chk("no_re_after_reset", re_log.size(), 0);
    out_ready = 1'b1;
    push_word(9'h1E1, 9'h02D, 9'h0B4, 9'h14B);
    wait_valid("fresh_latency", 3);
    wait_idle();
    chk("count_after_reset", word_count, 1);

    for (int i = 0; i < 300 && !saw_wrap; i++) step();
    chk("wrap_seen", saw_wrap, 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
